// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Holds opcode/funct constants, ALU operation codes, FSM states and the strobe bundle.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [2:0] ALU_RFUNCT = 3'b111;
  localparam logic [2:0] ALU_ADD    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_AND    = 3'b110;
  localparam logic [2:0] ALU_LUI    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    JR        = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       jal;
    logic       alu_src_a;
    logic       branch_eq;
    logic       branch_ne;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;
  } ctrl_t;

  // States in which the FSM waits on the memory handshake.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ORI:  return ALU_OR;
      OP_ANDI: return ALU_AND;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles; expired is high while the count equals limit.
module mem_wait_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             count_en,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory handshake and wait-cycle timeout.
// Strobes are decoded from the state plus mem_ready so handshakes complete in the ready cycle.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int ALUOP_W  = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OP,
  input  logic [5:0]         Funct,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               JAL,
  output logic               ALUSrcA,
  output logic               BranchEQ,
  output logic               BranchNE,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               mem_timeout
);

  localparam logic [7:0] WAIT_LIMIT = WAIT_MAX[7:0];

  state_t state, next_state;
  ctrl_t  ctrl;
  logic   in_mem, expired, timer_clear, timer_en;

  assign in_mem      = is_mem_state(state);
  // Counting stops at the limit; the expired cycle either completes (ready) or aborts.
  assign timer_en    = in_mem && !mem_ready && !expired;
  assign timer_clear = reset || !in_mem || mem_ready || expired;

  mem_wait_timer #(
    .CNT_W(8)
  ) u_wait_timer (
    .clk     (clk),
    .clear   (timer_clear),
    .count_en(timer_en),
    .limit   (WAIT_LIMIT),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ctrl       = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALU_ADD;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          next_state    = DECODE;
        end else if (expired) begin
          ctrl.mem_read    = 1'b0;
          ctrl.mem_timeout = 1'b1;
        end
      end
      DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALU_ADD;
        case (OP)
          OP_LW, OP_SW:                      next_state = MEM_ADDR;
          OP_R:                              next_state = (Funct == FUNCT_JR) ? JR : EXEC_R;
          OP_ADDI, OP_ORI, OP_ANDI, OP_LUI:  next_state = EXEC_I;
          OP_BEQ, OP_BNE:                    next_state = BRANCH;
          OP_J, OP_JAL:                      next_state = JUMP;
          default: begin
            ctrl.illegal_op = 1'b1;
            next_state      = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALU_ADD;
        next_state     = (OP == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
        if (mem_ready) begin
          next_state = MEM_WB;
        end else if (expired) begin
          ctrl.mem_read    = 1'b0;
          ctrl.mem_timeout = 1'b1;
          next_state       = FETCH;
        end
      end
      MEM_WRITE: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
        if (mem_ready) begin
          ctrl.instr_done = 1'b1;
          next_state      = FETCH;
        end else if (expired) begin
          ctrl.mem_write   = 1'b0;
          ctrl.mem_timeout = 1'b1;
          next_state       = FETCH;
        end
      end
      MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        next_state      = FETCH;
      end
      EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_RFUNCT;
        next_state     = ALU_WB;
      end
      EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = imm_alu_op(OP);
        next_state     = ALU_WB;
      end
      ALU_WB: begin
        ctrl.reg_dst    = (OP == OP_R);
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        next_state      = FETCH;
      end
      BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_source  = 2'b01;
        ctrl.branch_eq  = (OP == OP_BEQ);
        ctrl.branch_ne  = (OP == OP_BNE);
        ctrl.instr_done = 1'b1;
        next_state      = FETCH;
      end
      JUMP: begin
        ctrl.pc_source  = 2'b10;
        ctrl.pc_write   = 1'b1;
        ctrl.jal        = (OP == OP_JAL);
        ctrl.reg_write  = (OP == OP_JAL);
        ctrl.instr_done = 1'b1;
        next_state      = FETCH;
      end
      JR: begin
        ctrl.pc_source  = 2'b11;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
        next_state      = FETCH;
      end
      default: next_state = FETCH;
    endcase
    if (reset) begin
      ctrl = '0;
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign IRWrite     = ctrl.ir_write;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign JAL         = ctrl.jal;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign BranchEQ    = ctrl.branch_eq;
  assign BranchNE    = ctrl.branch_ne;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign ALUOp       = ALUOP_W'(ctrl.alu_op);
  assign instr_done  = ctrl.instr_done;
  assign illegal_op  = ctrl.illegal_op;
  assign mem_timeout = ctrl.mem_timeout;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model expands each instruction and
// its memory wait plan into per-cycle expected strobes, compared against the DUT.
module tb_multicycle_control;

  localparam int WMAX = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] OP = '0;
  logic [5:0] Funct = '0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst, RegWrite;
  logic       JAL, ALUSrcA, BranchEQ, BranchNE, instr_done, illegal_op, mem_timeout;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;

  always #5 clk = ~clk;

  multicycle_control #(
    .ALUOP_W (3),
    .WAIT_MAX(WMAX)
  ) dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .JAL(JAL), .ALUSrcA(ALUSrcA), .BranchEQ(BranchEQ), .BranchNE(BranchNE),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  typedef struct packed {
    logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst, RegWrite;
    logic       JAL, ALUSrcA, BranchEQ, BranchNE;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic       instr_done, illegal_op, mem_timeout;
  } outs_t;

  typedef struct {
    outs_t      o;
    logic       rdy;
    logic [5:0] op;
    logic [5:0] fn;
  } step_t;

  outs_t dut_o;
  assign dut_o = {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst, RegWrite,
                  JAL, ALUSrcA, BranchEQ, BranchNE, ALUSrcB, PCSource, ALUOp,
                  instr_done, illegal_op, mem_timeout};

  step_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic add(input outs_t o, input logic rdy, input logic [5:0] op, input logic [5:0] fn);
    step_t s;
    s.o = o; s.rdy = rdy; s.op = op; s.fn = fn;
    q.push_back(s);
  endtask

  // A memory access with a given number of not-ready cycles; more than WMAX means stuck.
  task automatic access(input outs_t wait_o, input outs_t done_o, input outs_t tmo_o,
                        input int waits, input logic [5:0] op, input logic [5:0] fn,
                        output bit ok);
    int lows;
    lows = (waits > WMAX) ? WMAX : waits;
    for (int i = 0; i < lows; i++) add(wait_o, 1'b0, op, fn);
    if (waits > WMAX) begin
      add(tmo_o, 1'b0, op, fn);
      ok = 1'b0;
    end else begin
      add(done_o, 1'b1, op, fn);
      ok = 1'b1;
    end
  endtask

  function automatic outs_t fetch_o(input bit done, input bit tmo);
    outs_t o = '0;
    o.MemRead = !tmo; o.ALUSrcB = 2'b01; o.ALUOp = 3'b100;
    o.IRWrite = done; o.PCWrite = done; o.mem_timeout = tmo;
    return o;
  endfunction

  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    bit ok;
    outs_t o, w, d, t;
    int fwait;
    fwait = fw;
    ok = 1'b0;
    while (!ok) begin
      access(fetch_o(0, 0), fetch_o(1, 0), fetch_o(0, 1), fwait, 6'($urandom), 6'($urandom), ok);
      fwait = 0;
    end
    o = '0; o.ALUSrcB = 2'b11; o.ALUOp = 3'b100;
    case (op)
      6'h23, 6'h2B: begin
        add(o, 1'($urandom), op, fn);
        o = '0; o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10; o.ALUOp = 3'b100;
        add(o, 1'($urandom), op, fn);
        w = '0; w.IorD = 1'b1;
        t = w;  t.mem_timeout = 1'b1;
        if (op == 6'h23) begin
          w.MemRead = 1'b1;
          access(w, w, t, mw, op, fn, ok);
          if (ok) begin
            o = '0; o.MemtoReg = 1'b1; o.RegWrite = 1'b1; o.instr_done = 1'b1;
            add(o, 1'($urandom), op, fn);
          end
        end else begin
          w.MemWrite = 1'b1;
          d = w; d.instr_done = 1'b1;
          access(w, d, t, mw, op, fn, ok);
        end
      end
      6'h00: begin
        add(o, 1'($urandom), op, fn);
        if (fn == 6'h08) begin
          o = '0; o.PCSource = 2'b11; o.PCWrite = 1'b1; o.instr_done = 1'b1;
          add(o, 1'($urandom), op, fn);
        end else begin
          o = '0; o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b00; o.ALUOp = 3'b111;
          add(o, 1'($urandom), op, fn);
          o = '0; o.RegDst = 1'b1; o.RegWrite = 1'b1; o.instr_done = 1'b1;
          add(o, 1'($urandom), op, fn);
        end
      end
      6'h08, 6'h0C, 6'h0D, 6'h0F: begin
        add(o, 1'($urandom), op, fn);
        o = '0; o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10;
        o.ALUOp = (op == 6'h0D) ? 3'b101 : (op == 6'h0C) ? 3'b110 : (op == 6'h0F) ? 3'b000 : 3'b100;
        add(o, 1'($urandom), op, fn);
        o = '0; o.RegWrite = 1'b1; o.instr_done = 1'b1;
        add(o, 1'($urandom), op, fn);
      end
      6'h04, 6'h05: begin
        add(o, 1'($urandom), op, fn);
        o = '0; o.ALUSrcA = 1'b1; o.ALUOp = 3'b001; o.PCSource = 2'b01;
        o.BranchEQ = (op == 6'h04); o.BranchNE = (op == 6'h05); o.instr_done = 1'b1;
        add(o, 1'($urandom), op, fn);
      end
      6'h02, 6'h03: begin
        add(o, 1'($urandom), op, fn);
        o = '0; o.PCSource = 2'b10; o.PCWrite = 1'b1; o.instr_done = 1'b1;
        o.JAL = (op == 6'h03); o.RegWrite = (op == 6'h03);
        add(o, 1'($urandom), op, fn);
      end
      default: begin
        o.illegal_op = 1'b1;
        add(o, 1'($urandom), op, fn);
      end
    endcase
  endtask

  task automatic step(input step_t s, output outs_t got);
    @(negedge clk);
    mem_ready = s.rdy; OP = s.op; Funct = s.fn;
    #1;
    got = dut_o;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom); OP = 6'($urandom); Funct = 6'($urandom);
      #1;
      n_cmp++;
      if (dut_o !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs cycle %0d: got %h want 0", i, dut_o);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_addi();
    step_t s; outs_t got; int cyc = 0; int dones = 0;
    model_instr(6'h08, 6'h00, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); step(s, got); n_cmp++;
      if (got !== s.o) begin n_bad++; $display("FAIL addi cycle %0d: got %h want %h", cyc, got, s.o); end
      if (cyc == 3) begin
        n_cmp++;
        if (got.RegWrite !== 1'b1 || got.RegDst !== 1'b0) begin
          n_bad++; $display("FAIL addi_wb RegWrite/RegDst: got %b%b want 10", got.RegWrite, got.RegDst);
        end
      end
      dones += int'(got.instr_done);
      cyc++;
    end
    n_cmp++;
    if (dones != 1) begin n_bad++; $display("FAIL addi_done_count: got %0d want 1", dones); end
  endtask

  task automatic test_lw_wait();
    step_t s; outs_t got; int cyc = 0; int reads = 0; int done_at = -1;
    model_instr(6'h23, 6'h00, 0, 3);
    while (q.size() > 0) begin
      s = q.pop_front(); step(s, got); n_cmp++;
      if (got !== s.o) begin n_bad++; $display("FAIL lw_wait cycle %0d: got %h want %h", cyc, got, s.o); end
      if (got.MemRead === 1'b1 && got.IorD === 1'b1) reads++;
      if (got.instr_done === 1'b1 && done_at < 0) done_at = cyc;
      cyc++;
    end
    n_cmp++;
    if (reads != 4) begin n_bad++; $display("FAIL lw_memread_cycles: got %0d want 4", reads); end
    n_cmp++;
    if (done_at != 7) begin n_bad++; $display("FAIL lw_latency: done in cycle %0d want 7", done_at); end
  endtask

  task automatic test_jal();
    step_t s; outs_t got; int cyc = 0;
    model_instr(6'h03, 6'h00, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); step(s, got); n_cmp++;
      if (got !== s.o) begin n_bad++; $display("FAIL jal cycle %0d: got %h want %h", cyc, got, s.o); end
      if (cyc == 2) begin
        n_cmp++;
        if ({got.PCWrite, got.PCSource, got.JAL, got.RegWrite} !== 5'b11011) begin
          n_bad++; $display("FAIL jal_jump_strobes: got %b want 11011", {got.PCWrite, got.PCSource, got.JAL, got.RegWrite});
        end
      end
      cyc++;
    end
  endtask

  task automatic test_illegal();
    step_t s; outs_t got; int cyc = 0; int writes = 0;
    model_instr(6'h3F, 6'h00, 0, 0);
    model_instr(6'h0D, 6'h00, 0, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); step(s, got); n_cmp++;
      if (got !== s.o) begin n_bad++; $display("FAIL illegal cycle %0d: got %h want %h", cyc, got, s.o); end
      if (cyc == 1) begin
        n_cmp++;
        if (got.illegal_op !== 1'b1) begin n_bad++; $display("FAIL illegal_pulse: got %b want 1", got.illegal_op); end
      end
      if (cyc < 2) writes += int'(got.RegWrite) + int'(got.MemWrite);
      cyc++;
    end
    n_cmp++;
    if (writes != 0) begin n_bad++; $display("FAIL illegal_writes: got %0d want 0", writes); end
  endtask

  task automatic test_timeout();
    step_t s; outs_t got; int cyc = 0; int tmo_at = -1; int tmos = 0;
    model_instr(6'h2B, 6'h00, 0, WMAX + 1);
    while (q.size() > 0) begin
      s = q.pop_front(); step(s, got); n_cmp++;
      if (got !== s.o) begin n_bad++; $display("FAIL sw_timeout cycle %0d: got %h want %h", cyc, got, s.o); end
      if (got.mem_timeout === 1'b1 && tmo_at < 0) tmo_at = cyc;
      cyc++;
    end
    n_cmp++;
    if (tmo_at != 3 + WMAX) begin n_bad++; $display("FAIL sw_timeout_cycle: got %0d want %0d", tmo_at, 3 + WMAX); end
    // Ready in the 4th wait cycle, then ready exactly at the limit, then stuck fetch and stuck load.
    model_instr(6'h2B, 6'h00, 0, WMAX - 1);
    model_instr(6'h2B, 6'h00, 0, WMAX);
    model_instr(6'h00, 6'h20, WMAX, 0);
    model_instr(6'h0F, 6'h00, WMAX + 1, 0);
    model_instr(6'h23, 6'h00, 0, WMAX + 1);
    model_instr(6'h04, 6'h00, 0, 0);
    cyc = 0;
    while (q.size() > 0) begin
      s = q.pop_front(); step(s, got); n_cmp++;
      if (got !== s.o) begin n_bad++; $display("FAIL timeout_edges cycle %0d: got %h want %h", cyc, got, s.o); end
      tmos += int'(got.mem_timeout);
      cyc++;
    end
    n_cmp++;
    if (tmos != 2) begin n_bad++; $display("FAIL timeout_edges_count: got %0d want 2", tmos); end
  endtask

  task automatic test_reset_mid_wait();
    step_t s; outs_t got; int cyc = 0;
    model_instr(6'h23, 6'h00, 0, 3);
    for (int i = 0; i < 4; i++) begin
      s = q.pop_front(); step(s, got); n_cmp++;
      if (got !== s.o) begin n_bad++; $display("FAIL rst_mid_pre cycle %0d: got %h want %h", i, got, s.o); end
    end
    q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b1; mem_ready = (i == 1);
      #1;
      n_cmp++;
      if (dut_o !== '0) begin n_bad++; $display("FAIL rst_mid_outputs cycle %0d: got %h want 0", i, dut_o); end
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0;
    model_instr(6'h00, 6'h08, WMAX, 0);
    while (q.size() > 0) begin
      s = q.pop_front(); step(s, got); n_cmp++;
      if (got !== s.o) begin n_bad++; $display("FAIL rst_mid_post cycle %0d: got %h want %h", cyc, got, s.o); end
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    step_t s; outs_t got; int cyc = 0;
    logic [5:0] ops [13];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h3F};
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 12)];
      fn = ($urandom_range(0, 2) == 0) ? 6'h08 : 6'($urandom);
      model_instr(op, fn, $urandom_range(0, WMAX + 1), $urandom_range(0, WMAX + 1));
    end
    while (q.size() > 0) begin
      s = q.pop_front(); step(s, got); n_cmp++;
      if (got !== s.o) begin n_bad++; $display("FAIL back_to_back cycle %0d op %h: got %h want %h", cyc, s.op, got, s.o); end
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_jal();
    test_illegal();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
